// File: rtl/sbox_share_feeder.sv
// Feeds 2-share nibble pairs plus fresh randomness into the masked Skinny S-box
// step stage, tracks items through its fixed latency and buffers the results.
module sbox_share_feeder #(
  parameter int LATENCY   = 1,
  parameter int PIPELINE  = 1,
  parameter int IN_DEPTH  = 4,
  parameter int OUT_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in0,
  input  logic [3:0]  in1,
  input  logic        r_valid,
  input  logic [63:0] r_in,
  output logic        r_ready,
  output logic [3:0]  st_in0,
  output logic [3:0]  st_in1,
  output logic [63:0] st_r,
  input  logic [3:0]  st_out0,
  input  logic [3:0]  st_out1,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  out0,
  output logic [3:0]  out1
);

  localparam int IPW = $clog2(IN_DEPTH);
  localparam int OPW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int CW  = $clog2(OUT_DEPTH + 1);
  localparam logic [IPW:0]   IN_FULL  = (IPW + 1)'(IN_DEPTH);
  localparam logic [CW:0]    OD_CRED  = (CW + 1)'(OUT_DEPTH);
  localparam logic [OPW-1:0] OUT_LAST = OPW'(OUT_DEPTH - 1);

  logic [3:0]         fifo0_q [IN_DEPTH];
  logic [3:0]         fifo1_q [IN_DEPTH];
  logic [IPW-1:0]     fwr_q, frd_q;
  logic [IPW:0]       fcnt_q, fcnt_d;
  logic [3:0]         st0_q, st1_q;
  logic [63:0]        str_q;
  logic [LATENCY-1:0] vsr_q, vsr_d;
  logic [CW-1:0]      infl_q, infl_d;
  logic [CW-1:0]      ocnt_q, ocnt_d;
  logic [3:0]         ob0_q [OUT_DEPTH];
  logic [3:0]         ob1_q [OUT_DEPTH];
  logic [OPW-1:0]     owr_q, ord_q;
  logic               push, issue, cap, pop, credit_ok;

  function automatic logic [OPW-1:0] onext(input logic [OPW-1:0] p);
    return (p == OUT_LAST) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    credit_ok = ({1'b0, infl_q} + {1'b0, ocnt_q}) < OD_CRED;
    issue     = (fcnt_q != '0) && r_valid && credit_ok &&
                ((PIPELINE != 0) || (infl_q == '0));
    // A same-cycle issue frees the head slot, so a full FIFO still accepts.
    in_ready  = (fcnt_q != IN_FULL) || issue;
    push      = in_valid && in_ready;
    cap       = vsr_q[LATENCY-1];
    out_valid = (ocnt_q != '0);
    pop       = out_valid && out_ready;
    r_ready   = issue;
    vsr_d     = (vsr_q << 1) | LATENCY'(issue);

    fcnt_d = fcnt_q;
    if (push && !issue)      fcnt_d = fcnt_q + 1'b1;
    else if (!push && issue) fcnt_d = fcnt_q - 1'b1;

    infl_d = infl_q;
    if (issue && !cap)      infl_d = infl_q + 1'b1;
    else if (!issue && cap) infl_d = infl_q - 1'b1;

    ocnt_d = ocnt_q;
    if (cap && !pop)      ocnt_d = ocnt_q + 1'b1;
    else if (!cap && pop) ocnt_d = ocnt_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo0_q[fwr_q] <= in0;
      fifo1_q[fwr_q] <= in1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fwr_q  <= '0;
      frd_q  <= '0;
      fcnt_q <= '0;
      st0_q  <= '0;
      st1_q  <= '0;
      str_q  <= '0;
      vsr_q  <= '0;
      infl_q <= '0;
      ocnt_q <= '0;
      owr_q  <= '0;
      ord_q  <= '0;
      for (int unsigned i = 0; i < OUT_DEPTH; i++) begin
        ob0_q[i] <= '0;
        ob1_q[i] <= '0;
      end
    end else begin
      if (push) fwr_q <= fwr_q + 1'b1;
      // Step-stage inputs only move on issue so the shares never see foreign data.
      if (issue) begin
        st0_q <= fifo0_q[frd_q];
        st1_q <= fifo1_q[frd_q];
        str_q <= r_in;
        frd_q <= frd_q + 1'b1;
      end
      if (cap) begin
        ob0_q[owr_q] <= st_out0;
        ob1_q[owr_q] <= st_out1;
        owr_q        <= onext(owr_q);
      end
      if (pop) ord_q <= onext(ord_q);
      fcnt_q <= fcnt_d;
      vsr_q  <= vsr_d;
      infl_q <= infl_d;
      ocnt_q <= ocnt_d;
    end
  end

  assign st_in0 = st0_q;
  assign st_in1 = st1_q;
  assign st_r   = str_q;
  assign out0   = ob0_q[ord_q];
  assign out1   = ob1_q[ord_q];

endmodule

// File: tb/tb_sbox_share_feeder.sv
// Bench for sbox_share_feeder: a pipelined latency-1 instance and a
// non-pipelined latency-3 instance, each driving a behavioural masked S-box stage.
module tb_sbox_share_feeder;

  typedef struct {
    logic [3:0] in0;
    logic [3:0] in1;
    logic [3:0] sx;
  } vec_t;

  vec_t tbl [16];

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [63:0] r_val = 64'h0123_4567_89ab_cdef;

  logic        rst_n_a, in_valid_a, in_ready_a, r_valid_a, r_ready_a;
  logic        out_valid_a, out_ready_a;
  logic [3:0]  in0_a, in1_a, st_in0_a, st_in1_a, st_out0_a, st_out1_a;
  logic [3:0]  out0_a, out1_a, cur_exp_a;
  logic [63:0] st_r_a;

  logic        rst_n_b, in_valid_b, in_ready_b, r_valid_b, r_ready_b;
  logic        out_valid_b, out_ready_b;
  logic [3:0]  in0_b, in1_b, st_in0_b, st_in1_b, st_out0_b, st_out1_b;
  logic [3:0]  out0_b, out1_b, cur_exp_b;
  logic [63:0] st_r_b;

  sbox_share_feeder #(.LATENCY(1), .PIPELINE(1), .IN_DEPTH(4), .OUT_DEPTH(2)) u_a (
    .clk(clk), .rst_n(rst_n_a), .in_valid(in_valid_a), .in_ready(in_ready_a),
    .in0(in0_a), .in1(in1_a), .r_valid(r_valid_a), .r_in(r_val), .r_ready(r_ready_a),
    .st_in0(st_in0_a), .st_in1(st_in1_a), .st_r(st_r_a),
    .st_out0(st_out0_a), .st_out1(st_out1_a),
    .out_valid(out_valid_a), .out_ready(out_ready_a), .out0(out0_a), .out1(out1_a)
  );

  sbox_share_feeder #(.LATENCY(3), .PIPELINE(0), .IN_DEPTH(4), .OUT_DEPTH(2)) u_b (
    .clk(clk), .rst_n(rst_n_b), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .in0(in0_b), .in1(in1_b), .r_valid(r_valid_b), .r_in(r_val), .r_ready(r_ready_b),
    .st_in0(st_in0_b), .st_in1(st_in1_b), .st_r(st_r_b),
    .st_out0(st_out0_b), .st_out1(st_out1_b),
    .out_valid(out_valid_b), .out_ready(out_ready_b), .out0(out0_b), .out1(out1_b)
  );

  function automatic logic [3:0] sbox(input logic [3:0] x);
    case (x)
      4'h0: return 4'hc; 4'h1: return 4'h6; 4'h2: return 4'h9; 4'h3: return 4'h0;
      4'h4: return 4'h1; 4'h5: return 4'ha; 4'h6: return 4'h2; 4'h7: return 4'hb;
      4'h8: return 4'h3; 4'h9: return 4'h8; 4'ha: return 4'h5; 4'hb: return 4'hd;
      4'hc: return 4'h4; 4'hd: return 4'he; 4'he: return 4'h7; default: return 4'hf;
    endcase
  endfunction

  // Masked step-stage models: share0 = S(x) ^ r, share1 = r.
  assign st_out0_a = sbox(st_in0_a ^ st_in1_a) ^ st_r_a[3:0];
  assign st_out1_a = st_r_a[3:0];

  logic [11:0] g1_b = '0, g2_b = '0;
  always @(posedge clk) begin
    g1_b <= {st_in0_b, st_in1_b, st_r_b[3:0]};
    g2_b <= g1_b;
  end
  assign st_out0_b = sbox(g2_b[11:8] ^ g2_b[7:4]) ^ g2_b[3:0];
  assign st_out1_b = g2_b[3:0];

  initial forever begin
    @(posedge clk); #1;
    r_val = r_val + 64'h9e37_79b9_7f4a_7c15;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  logic [3:0]  expq_a [$], rq_a [$], expq_b [$], rq_b [$];
  int          iss_cyc_b [$];
  int          n_iss_a = 0, n_out_a = 0, n_out_b = 0;
  logic [63:0] last_r_a = '0;

  always @(negedge clk) if (rst_n_a) begin
    if (in_valid_a && in_ready_a) expq_a.push_back(cur_exp_a);
    if (r_ready_a) begin
      rq_a.push_back(r_val[3:0]);
      last_r_a = r_val;
      n_iss_a++;
    end
    if (out_valid_a && out_ready_a) begin
      n_out_a++;
      if (expq_a.size() == 0 || rq_a.size() == 0) begin
        checks++; errors++;
        $display("FAIL out_a_unexpected: got %0h/%0h expected no output", out0_a, out1_a);
      end else begin
        chk("out_a_recombined", 64'(out0_a ^ out1_a), 64'(expq_a.pop_front()));
        chk("out_a_mask", 64'(out1_a), 64'(rq_a.pop_front()));
      end
    end
  end

  always @(negedge clk) if (rst_n_b) begin
    if (in_valid_b && in_ready_b) expq_b.push_back(cur_exp_b);
    if (r_ready_b) begin
      rq_b.push_back(r_val[3:0]);
      iss_cyc_b.push_back(cyc);
    end
    if (out_valid_b && out_ready_b) begin
      n_out_b++;
      if (expq_b.size() == 0 || rq_b.size() == 0) begin
        checks++; errors++;
        $display("FAIL out_b_unexpected: got %0h/%0h expected no output", out0_b, out1_b);
      end else begin
        chk("out_b_recombined", 64'(out0_b ^ out1_b), 64'(expq_b.pop_front()));
        chk("out_b_mask", 64'(out1_b), 64'(rq_b.pop_front()));
      end
    end
  end

  task automatic push_a(input vec_t v);
    bit ok = 1'b0;
    in_valid_a = 1'b1; in0_a = v.in0; in1_a = v.in1; cur_exp_a = v.sx;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge clk); ok = in_ready_a; step();
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL push_a_timeout: got in_ready 0 expected 1");
    end
  endtask

  task automatic push_b(input vec_t v);
    bit ok = 1'b0;
    in_valid_b = 1'b1; in0_b = v.in0; in1_b = v.in1; cur_exp_b = v.sx;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge clk); ok = in_ready_b; step();
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL push_b_timeout: got in_ready 0 expected 1");
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int   base_iss, base_out;
    bit   seen;
    logic [63:0] r_snap;

    tbl[0]  = '{4'h7, 4'h7, 4'hc}; tbl[1]  = '{4'h0, 4'h1, 4'h6};
    tbl[2]  = '{4'hb, 4'h9, 4'h9}; tbl[3]  = '{4'h5, 4'h6, 4'h0};
    tbl[4]  = '{4'hc, 4'h8, 4'h1}; tbl[5]  = '{4'hf, 4'ha, 4'ha};
    tbl[6]  = '{4'h2, 4'h4, 4'h2}; tbl[7]  = '{4'h9, 4'he, 4'hb};
    tbl[8]  = '{4'h8, 4'h0, 4'h3}; tbl[9]  = '{4'h3, 4'ha, 4'h8};
    tbl[10] = '{4'h6, 4'hc, 4'h5}; tbl[11] = '{4'hd, 4'h6, 4'hd};
    tbl[12] = '{4'h1, 4'hd, 4'h4}; tbl[13] = '{4'he, 4'h3, 4'he};
    tbl[14] = '{4'ha, 4'h4, 4'h7}; tbl[15] = '{4'h4, 4'hb, 4'hf};

    rst_n_a = 1'b0; in_valid_a = 1'b0; in0_a = '0; in1_a = '0; r_valid_a = 1'b0;
    out_ready_a = 1'b0; cur_exp_a = '0;
    rst_n_b = 1'b0; in_valid_b = 1'b0; in0_b = '0; in1_b = '0; r_valid_b = 1'b0;
    out_ready_b = 1'b0; cur_exp_b = '0;

    // Reset and idle with randomness offered but nothing queued.
    repeat (2) step();
    rst_n_a = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready_a), 64'd1);
    chk("rst_out_valid", 64'(out_valid_a), 64'd0);
    chk("rst_r_ready", 64'(r_ready_a), 64'd0);
    chk("rst_st_r", st_r_a, 64'd0);
    chk("rst_out0", 64'(out0_a), 64'd0);
    step();
    r_valid_a = 1'b1;
    repeat (2) step();
    @(negedge clk);
    chk("idle_r_ready", 64'(r_ready_a), 64'd0);
    chk("idle_st_in0", 64'(st_in0_a), 64'd0);

    // Single item through the latency-1 stage.
    step();
    in_valid_a = 1'b1; in0_a = 4'ha; in1_a = 4'h5; cur_exp_a = 4'hf;
    step();
    in_valid_a = 1'b0;
    @(negedge clk);
    chk("single_r_ready", 64'(r_ready_a), 64'd1);
    r_snap = r_val;
    step();
    @(negedge clk);
    chk("single_st_in0", 64'(st_in0_a), 64'ha);
    chk("single_st_in1", 64'(st_in1_a), 64'h5);
    chk("single_st_r", st_r_a, r_snap);
    chk("single_r_ready_low", 64'(r_ready_a), 64'd0);
    chk("single_out_valid_early", 64'(out_valid_a), 64'd0);
    step();
    @(negedge clk);
    chk("single_out_valid", 64'(out_valid_a), 64'd1);
    chk("single_recombined", 64'(out0_a ^ out1_a), 64'hf);
    chk("single_mask", 64'(out1_a), 64'(r_snap[3:0]));
    step();
    out_ready_a = 1'b1;
    repeat (2) step();

    // Streaming all 16 nibble values back-to-back.
    base_out = n_out_a;
    base_iss = n_iss_a;
    for (int i = 0; i < 16; i++) push_a(tbl[i]);
    in_valid_a = 1'b0;
    for (int k = 0; k < 200 && n_out_a < base_out + 16; k++) step();
    chk("stream_outputs", 64'(n_out_a - base_out), 64'd16);
    chk("stream_issues", 64'(n_iss_a - base_iss), 64'd16);

    // Backpressure: two credits, four FIFO slots.
    out_ready_a = 1'b0;
    base_out = n_out_a;
    base_iss = n_iss_a;
    for (int i = 0; i < 6; i++) push_a(tbl[i]);
    in_valid_a = 1'b0;
    repeat (3) step();
    @(negedge clk);
    chk("bp_issues", 64'(n_iss_a - base_iss), 64'd2);
    chk("bp_in_ready", 64'(in_ready_a), 64'd0);
    chk("bp_out_valid", 64'(out_valid_a), 64'd1);
    chk("bp_no_pop", 64'(n_out_a - base_out), 64'd0);
    step();
    out_ready_a = 1'b1;
    for (int k = 0; k < 200 && n_out_a < base_out + 6; k++) step();
    chk("bp_drained", 64'(n_out_a - base_out), 64'd6);

    // Randomness starvation.
    r_valid_a = 1'b0;
    push_a(tbl[6]);
    push_a(tbl[7]);
    in_valid_a = 1'b0;
    base_iss = n_iss_a;
    repeat (3) step();
    @(negedge clk);
    chk("starve_issues", 64'(n_iss_a - base_iss), 64'd0);
    chk("starve_r_ready", 64'(r_ready_a), 64'd0);
    chk("starve_st_in0", 64'(st_in0_a), 64'hf);
    chk("starve_st_in1", 64'(st_in1_a), 64'ha);
    chk("starve_st_r", st_r_a, last_r_a);
    step();
    r_valid_a = 1'b1;
    step();
    r_valid_a = 1'b0;
    repeat (3) step();
    @(negedge clk);
    chk("starve_one_issue", 64'(n_iss_a - base_iss), 64'd1);
    chk("starve_st_in0_next", 64'(st_in0_a), 64'h2);
    chk("starve_st_in1_next", 64'(st_in1_a), 64'h4);
    chk("starve_st_r_next", st_r_a, last_r_a);
    step();
    r_valid_a = 1'b1;
    for (int k = 0; k < 100 && expq_a.size() != 0; k++) step();
    chk("starve_drained", 64'(expq_a.size()), 64'd0);

    // Non-pipelined latency-3 instance: issue spacing.
    step();
    rst_n_b = 1'b1; r_valid_b = 1'b1; out_ready_b = 1'b1;
    push_b(tbl[8]);
    push_b(tbl[9]);
    push_b(tbl[10]);
    in_valid_b = 1'b0;
    for (int k = 0; k < 100 && n_out_b < 3; k++) step();
    chk("b_outputs", 64'(n_out_b), 64'd3);
    chk("b_issues", 64'(iss_cyc_b.size()), 64'd3);
    chk("b_gap1", 64'(iss_cyc_b[1] - iss_cyc_b[0]), 64'd4);
    chk("b_gap2", 64'(iss_cyc_b[2] - iss_cyc_b[1]), 64'd4);

    // Reset with one item in flight discards it.
    push_b(tbl[11]);
    in_valid_b = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      seen = r_ready_b;
      step();
    end
    chk("b_inflight_issue", 64'(seen), 64'd1);
    rst_n_b = 1'b0;
    repeat (2) step();
    rst_n_b = 1'b1;
    expq_b.delete();
    rq_b.delete();
    base_out = n_out_b;
    @(negedge clk);
    chk("b_rst_st_r", st_r_b, 64'd0);
    chk("b_rst_in_ready", 64'(in_ready_b), 64'd1);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("b_rst_out_valid", 64'(out_valid_b), 64'd0);
    end
    chk("b_rst_no_output", 64'(n_out_b - base_out), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
